dmem_req_ctrl: RTL and testbench

- MEM-stage data-memory requester; the write/request side of the load path that WB consumes.
- Turns the pipeline's load/store intent into a registered, word-aligned request to the data cache. Generates byte enables and lane-replicated store data.
- Holds the request until the cache responds, stalls the pipeline meanwhile, and returns the raw 32-bit read word.
- WB performs load byte/halfword extraction; this block does none.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/store_align.sv | 51 +++++
 rtl/dmem_req_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_req_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the MEM-stage data-memory path.
package rv32i_types;

    localparam int dmem_mbe_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    // Access size as log2(bytes): 0 byte, 1 halfword, 2 word.
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        logic [1:0] size;
        case (load_funct3_t'(funct3))
            lb, lbu: size = 2'd0;
            lh, lhu: size = 2'd1;
            default: size = 2'd2;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/store_align.sv
// Byte-enable, lane-replicated store data and misalignment detection for one
// load/store; purely combinational.
module store_align
    import rv32i_types::*;
#(
    parameter int width     = 32,
    parameter int mbe_width = dmem_mbe_width
) (
    input  logic                         is_store,
    input  logic [2:0]                   funct3,
    input  logic [$clog2(mbe_width)-1:0] off,
    input  logic [width-1:0]             rs2,
    output logic [mbe_width-1:0]         mbe,
    output logic [width-1:0]             wdata,
    output logic                         misaligned
);

    logic [1:0] size;

    always_comb begin
        size       = access_size(funct3);
        mbe        = '1;
        wdata      = '0;
        misaligned = 1'b0;

        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            default: misaligned = (off != '0);
        endcase

        // Loads always fetch the whole word; WB does the lane extraction.
        if (is_store) begin
            case (size)
                2'd0: begin
                    wdata = {(width/8){rs2[7:0]}};
                    mbe   = mbe_width'(1) << off;
                end
                2'd1: begin
                    wdata = {(width/16){rs2[15:0]}};
                    mbe   = mbe_width'(3) << off;
                end
                default: begin
                    wdata = rs2;
                    mbe   = '1;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-memory requester: issues a registered word-aligned request,
// stalls until the cache responds and hands the raw read word to WB.
//   state | meaning
//   IDLE  | no request outstanding; a legal aligned op issues this cycle
//   BUSY  | request held on the cache port until dmem_resp_i
//   DONE  | access complete; wait for the instruction to leave MEM
module dmem_req_ctrl
    import rv32i_types::*;
#(
    parameter int width     = 32,
    parameter int mbe_width = dmem_mbe_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_mem_read_i,
    input  logic                 MEM_mem_write_i,
    input  logic [2:0]           MEM_funct3_i,
    input  logic [width-1:0]     MEM_alu_out_i,
    input  logic [width-1:0]     MEM_rs2_i,
    input  logic                 MEM_advance_i,
    input  logic                 MEM_flush_i,
    input  logic                 dmem_resp_i,
    input  logic [width-1:0]     dmem_rdata_i,
    output logic [width-1:0]     dmem_address_o,
    output logic                 dmem_read_o,
    output logic                 dmem_write_o,
    output logic [mbe_width-1:0] dmem_mbe_o,
    output logic [width-1:0]     dmem_wdata_o,
    output logic                 MEM_stall_o,
    output logic [width-1:0]     MEM_rdata_o,
    output logic                 MEM_misaligned_o
);

    localparam int off_w = $clog2(mbe_width);

    dmem_state_t          state;
    logic                 discard;
    logic                 op;
    logic                 issue;
    logic                 misaligned;
    logic [mbe_width-1:0] align_mbe;
    logic [width-1:0]     align_wdata;

    store_align #(
        .width     (width),
        .mbe_width (mbe_width)
    ) u_store_align (
        .is_store   (MEM_mem_write_i),
        .funct3     (MEM_funct3_i),
        .off        (MEM_alu_out_i[off_w-1:0]),
        .rs2        (MEM_rs2_i),
        .mbe        (align_mbe),
        .wdata      (align_wdata),
        .misaligned (misaligned)
    );

    assign op    = (MEM_mem_read_i | MEM_mem_write_i) & ~MEM_flush_i;
    assign issue = (state == IDLE) & op & ~misaligned;

    // Gated by rst so every output is low while reset is held.
    assign MEM_stall_o      = rst & (issue | (state == BUSY));
    assign MEM_misaligned_o = rst & (state == IDLE) & op & misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            discard        <= 1'b0;
            dmem_address_o <= '0;
            dmem_read_o    <= 1'b0;
            dmem_write_o   <= 1'b0;
            dmem_mbe_o     <= '0;
            dmem_wdata_o   <= '0;
            MEM_rdata_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        dmem_address_o <= {MEM_alu_out_i[width-1:off_w], {off_w{1'b0}}};
                        dmem_mbe_o     <= align_mbe;
                        dmem_wdata_o   <= align_wdata;
                        dmem_write_o   <= MEM_mem_write_i;
                        dmem_read_o    <= ~MEM_mem_write_i;
                        discard        <= 1'b0;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    // A squashed access still runs to completion on the cache.
                    if (dmem_resp_i) begin
                        dmem_read_o  <= 1'b0;
                        dmem_write_o <= 1'b0;
                        discard      <= 1'b0;
                        if (discard | MEM_flush_i) begin
                            state <= IDLE;
                        end else begin
                            if (dmem_read_o) begin
                                MEM_rdata_o <= dmem_rdata_i;
                            end
                            state <= DONE;
                        end
                    end else if (MEM_flush_i) begin
                        discard <= 1'b1;
                    end
                end
                DONE: begin
                    if (MEM_advance_i | MEM_flush_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            a_rw_exclusive: assert (!(state == IDLE && op && MEM_mem_read_i && MEM_mem_write_i));
            a_store_funct3: assert (!(issue && MEM_mem_write_i && !(MEM_funct3_i inside {sb, sh, sw})));
            a_resp_in_busy: assert (!(dmem_resp_i && state != BUSY));
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: directed cases with literal expectations followed
// by random traffic compared against a transaction-level reference model.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, advance, flush, resp;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2, rdata_in;
    logic [31:0] address, wdata, rdata;
    logic        dread, dwrite, stall, misaligned;
    logic [3:0]  mbe;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: one outstanding access plus the last word WB received.
    bit          m_active, m_waiting, m_drop, m_is_write;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_mbe;

    always #5 clk = ~clk;

    dmem_req_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_mem_read_i   (mem_read),
        .MEM_mem_write_i  (mem_write),
        .MEM_funct3_i     (funct3),
        .MEM_alu_out_i    (alu_out),
        .MEM_rs2_i        (rs2),
        .MEM_advance_i    (advance),
        .MEM_flush_i      (flush),
        .dmem_resp_i      (resp),
        .dmem_rdata_i     (rdata_in),
        .dmem_address_o   (address),
        .dmem_read_o      (dread),
        .dmem_write_o     (dwrite),
        .dmem_mbe_o       (mbe),
        .dmem_wdata_o     (wdata),
        .MEM_stall_o      (stall),
        .MEM_rdata_o      (rdata),
        .MEM_misaligned_o (misaligned)
    );

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit exp_mis();
        return (int'(alu_out[1:0]) % size_of(funct3)) != 0;
    endfunction

    function automatic bit exp_op();
        return (mem_read || mem_write) && !flush;
    endfunction

    function automatic bit exp_idle();
        return !m_active && !m_waiting;
    endfunction

    function automatic bit exp_issue();
        return exp_idle() && exp_op() && !exp_mis();
    endfunction

    function automatic logic [3:0] exp_mbe();
        int sz = size_of(funct3);
        if (!mem_write) return 4'hF;
        return 4'(((1 << sz) - 1) << alu_out[1:0]);
    endfunction

    function automatic logic [31:0] exp_wdata();
        int sz = size_of(funct3);
        if (!mem_write) return 32'h0;
        if (sz == 1) return {24'h0, rs2[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, rs2[15:0]} * 32'h0001_0001;
        return rs2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic sample();
        @(negedge clk);
        chk("read",       32'(dread),      32'(m_active && !m_is_write));
        chk("write",      32'(dwrite),     32'(m_active && m_is_write));
        chk("address",    address,         m_addr);
        chk("mbe",        32'(mbe),        32'(m_mbe));
        chk("wdata",      wdata,           m_wdata);
        chk("stall",      32'(stall),      32'(m_active || exp_issue()));
        chk("misaligned", 32'(misaligned), 32'(exp_idle() && exp_op() && exp_mis()));
        chk("rdata",      rdata,           m_rdata);
    endtask

    task automatic model_reset();
        m_active = 0; m_waiting = 0; m_drop = 0; m_is_write = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_mbe = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (exp_idle()) begin
            if (exp_issue()) begin
                m_active   = 1;
                m_drop     = 0;
                m_is_write = mem_write;
                m_addr     = alu_out & ~32'h3;
                m_mbe      = exp_mbe();
                m_wdata    = exp_wdata();
            end
        end else if (m_active) begin
            if (resp) begin
                m_active = 0;
                if (!(m_drop || flush)) begin
                    m_waiting = 1;
                    if (!m_is_write) m_rdata = rdata_in;
                end
                m_drop = 0;
            end else if (flush) begin
                m_drop = 1;
            end
        end else if (advance || flush) begin
            m_waiting = 0;
        end
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        mem_read = rd; mem_write = wr; funct3 = f3; alu_out = a; rs2 = d;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        bit take_new;
        int kind;
        rst = 1'b0;
        nop();
        advance = 0; flush = 0; resp = 0; rdata_in = 0;
        model_reset();

        repeat (2) @(posedge clk);
        sample();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_write", 32'(dwrite), 32'h0);
        chk("rst_addr",  address, 32'h0);
        tick();
        rst = 1'b1;

        // sw with a 3-cycle cache
        set_op(1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
        sample();
        chk("t1_issue_stall", 32'(stall), 32'h1);
        chk("t1_issue_write", 32'(dwrite), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            resp = (i == 2);
            sample();
            chk("t1_write", 32'(dwrite), 32'h1);
            chk("t1_addr",  address, 32'h1000_0004);
            chk("t1_mbe",   32'(mbe), 32'hF);
            chk("t1_wdata", wdata, 32'hDEAD_BEEF);
            chk("t1_stall", 32'(stall), 32'h1);
            tick();
        end
        resp = 0; advance = 1;
        sample();
        chk("t1_done_stall", 32'(stall), 32'h0);
        chk("t1_done_write", 32'(dwrite), 32'h0);
        tick();

        // sb to byte lane 3, zero-wait cache
        set_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
        advance = 0;
        sample(); tick();
        resp = 1;
        sample();
        chk("t2_mbe",   32'(mbe), 32'h8);
        chk("t2_wdata", wdata, 32'hA5A5_A5A5);
        chk("t2_addr",  address, 32'h0000_0010);
        tick();
        resp = 0; advance = 1;
        sample(); tick();

        // lh, then hold in DONE without re-issuing
        set_op(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0);
        advance = 0;
        sample(); tick();
        resp = 1; rdata_in = 32'h1234_5678;
        sample();
        chk("t3_read", 32'(dread), 32'h1);
        chk("t3_mbe",  32'(mbe), 32'hF);
        tick();
        resp = 0; rdata_in = 0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t3_rdata",   rdata, 32'h1234_5678);
            chk("t3_noreiss", 32'(dread), 32'h0);
            chk("t3_stall",   32'(stall), 32'h0);
            tick();
        end
        advance = 1;
        sample(); tick();
        nop();
        sample(); tick();

        // misaligned sw
        set_op(1'b0, 1'b1, 3'b010, 32'h0000_0002, 32'h5555_5555);
        sample();
        chk("t4_mis",   32'(misaligned), 32'h1);
        chk("t4_stall", 32'(stall), 32'h0);
        chk("t4_write", 32'(dwrite), 32'h0);
        tick();
        nop();
        sample();
        chk("t4_mis_clr", 32'(misaligned), 32'h0);
        tick();

        // lw flushed while BUSY
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
        advance = 0;
        sample(); tick();
        flush = 1;
        sample();
        chk("t5_busy_stall", 32'(stall), 32'h1);
        tick();
        flush = 0; resp = 1; rdata_in = 32'hFFFF_FFFF;
        sample();
        chk("t5_resp_stall", 32'(stall), 32'h1);
        tick();
        resp = 0; rdata_in = 0; nop();
        sample();
        chk("t5_after_stall", 32'(stall), 32'h0);
        chk("t5_after_rdata", rdata, 32'h1234_5678);
        tick();
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0);
        sample();
        chk("t5_idle_issue", 32'(stall), 32'h1);
        tick();
        resp = 1; rdata_in = 32'hCAFE_F00D;
        sample(); tick();
        resp = 0; advance = 1;
        sample();
        chk("t5_new_rdata", rdata, 32'hCAFE_F00D);
        tick();

        // asynchronous reset in the middle of a store
        set_op(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'h1122_3344);
        advance = 0;
        sample(); tick();
        sample();
        chk("t6_pre_write", 32'(dwrite), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_write", 32'(dwrite), 32'h0);
        chk("t6_rst_read",  32'(dread), 32'h0);
        chk("t6_rst_addr",  address, 32'h0);
        chk("t6_rst_mbe",   32'(mbe), 32'h0);
        chk("t6_rst_wdata", wdata, 32'h0);
        chk("t6_rst_stall", 32'(stall), 32'h0);
        chk("t6_rst_rdata", rdata, 32'h0);
        chk("t6_rst_mis",   32'(misaligned), 32'h0);
        tick();
        rst = 1'b1;
        sample();
        chk("t6_reissue_stall", 32'(stall), 32'h1);
        tick();
        resp = 1;
        sample();
        chk("t6_write", 32'(dwrite), 32'h1);
        chk("t6_addr",  address, 32'h0000_0080);
        chk("t6_wdata", wdata, 32'h1122_3344);
        tick();
        resp = 0; advance = 1;
        sample(); tick();

        // random traffic against the model
        take_new = 1;
        for (int c = 0; c < 800; c++) begin
            if (take_new) begin
                kind = $urandom_range(0, 3);
                if (kind == 0) begin
                    nop();
                end else if (kind == 1) begin
                    case ($urandom_range(0, 4))
                        0: funct3 = 3'b000;
                        1: funct3 = 3'b001;
                        2: funct3 = 3'b010;
                        3: funct3 = 3'b100;
                        default: funct3 = 3'b101;
                    endcase
                    set_op(1'b1, 1'b0, funct3, $urandom, $urandom);
                end else begin
                    set_op(1'b0, 1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom);
                end
            end
            flush    = ($urandom_range(0, 9) == 0);
            resp     = m_active && ($urandom_range(0, 2) == 0);
            rdata_in = $urandom;
            advance  = !(m_active || exp_issue()) && ($urandom_range(0, 1) == 1);
            take_new = advance || flush;
            sample();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
